// File: rtl/uniboard_proto_pkg.sv
// uniboard_proto_pkg: host-link framing bytes and the UART arbiter state encoding
package uniboard_proto_pkg;
  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_END = 8'h17;
  localparam logic [7:0] CMD_ESC = 8'h18;
  typedef enum logic [2:0] {IDLE, START, DATA, ESC, END, GAP} tx_arb_state_t;
  function automatic logic needs_escape(input logic [7:0] b);
    return b == CMD_START || b == CMD_END || b == CMD_ESC;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: first valid requester after the last winner, wrapping, as one-hot and index
module rr_picker #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    ptr,
  output logic             any,
  output logic [N_REQ-1:0] win,
  output logic [IW-1:0]    win_idx
);
  logic [IW-1:0] j;
  assign any = |valid;
  // Scan farthest-first so the nearest valid requester after ptr overwrites the rest.
  always_comb begin
    win = '0;
    win_idx = '0;
    j = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = IW'((int'(ptr) + k) % N_REQ);
      if (valid[j]) begin
        win = '0;
        win[j] = 1'b1;
        win_idx = j;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of the host UART with 0x01/0x17 framing and 0x18 escaping
module uart_tx_arbiter
  import uniboard_proto_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_last,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   grant,
  output logic               abort,
  output logic [7:0]         tx_data,
  output logic               tx_send,
  input  logic               tx_busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  tx_arb_state_t state, state_n, ret, ret_n;
  logic [IW-1:0] ptr, gidx, win_idx;
  logic [N_REQ-1:0] win;
  logic [CW-1:0] cnt;
  logic [7:0] held, tx_q, cur, send_byte;
  logic any, held_last, v, l, ack, esc_now, time_up;
  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .valid(req_valid), .ptr(ptr), .any(any), .win(win), .win_idx(win_idx)
  );
  assign v = req_valid[gidx];
  assign l = req_last[gidx];
  assign cur = req_data[{gidx, 3'b000} +: 8];
  assign time_up = !v && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign tx_data = send_byte;
  assign req_ack = ack ? grant : '0;
  // GAP always follows a send; ret remembers where to resume afterwards.
  always_comb begin
    state_n = state;
    ret_n = ret;
    tx_send = 1'b0;
    send_byte = tx_q;
    ack = 1'b0;
    abort = 1'b0;
    esc_now = 1'b0;
    case (state)
      IDLE: state_n = any ? START : IDLE;
      START:
        if (!tx_busy) begin
          tx_send = 1'b1;
          send_byte = CMD_START;
          state_n = GAP;
          ret_n = DATA;
        end
      DATA:
        if (v && !tx_busy) begin
          tx_send = 1'b1;
          esc_now = needs_escape(cur);
          send_byte = esc_now ? CMD_ESC : cur;
          ack = !esc_now;
          state_n = GAP;
          ret_n = esc_now ? ESC : l ? END : DATA;
        end else if (time_up) begin
          abort = 1'b1;
          state_n = END;
        end
      ESC:
        if (!tx_busy) begin
          tx_send = 1'b1;
          send_byte = held;
          ack = 1'b1;
          state_n = GAP;
          ret_n = held_last ? END : DATA;
        end
      END:
        if (!tx_busy) begin
          tx_send = 1'b1;
          send_byte = CMD_END;
          state_n = GAP;
          ret_n = IDLE;
        end
      default: state_n = ret;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ret <= IDLE;
      ptr <= IW'(N_REQ - 1);
      gidx <= '0;
      grant <= '0;
      cnt <= '0;
      held <= '0;
      held_last <= 1'b0;
      tx_q <= '0;
    end else begin
      state <= state_n;
      ret <= ret_n;
      cnt <= (state != DATA || tx_send || time_up) ? '0 : !v ? cnt + 1'b1 : cnt;
      if (tx_send) tx_q <= send_byte;
      if (esc_now) begin
        held <= cur;
        held_last <= l;
      end
      if (state == IDLE && any) begin
        grant <= win;
        gidx <= win_idx;
        ptr <= win_idx;
      end
      if (state == GAP && ret == IDLE) grant <= '0;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a packet-level round-robin/framing reference model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int T_OUT = 20;
  typedef struct packed {logic [7:0] d; logic l;} ent_t;
  typedef struct packed {logic [7:0] b; logic [N-1:0] g;} exp_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] req_valid = '0, req_last = '0, acked = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] req_ack, grant;
  logic abort, tx_send, tx_busy = 1'b0, sent = 1'b0, prev_send = 1'b0, busy_force = 1'b0;
  logic [7:0] tx_data;
  int checks = 0, failures = 0, cyc = 0, bcnt = 0, mptr = N - 1, sends = 0;
  int abort_cnt = 0, abort_cyc = 0;
  int ack_cnt[N], ack_cyc[N];
  ent_t rq[N][$];
  ent_t mq[N][$];
  exp_t exq[$];

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(T_OUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ack(req_ack), .grant(grant), .abort(abort),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = rq[i].size() > 0;
      req_data[8*i +: 8] = rq[i].size() > 0 ? rq[i][0].d : 8'($urandom);
      req_last[i] = rq[i].size() > 0 && rq[i][0].l;
    end
  endtask

  function automatic void push(input logic [7:0] b, input int w);
    exp_t e;
    e.b = b;
    e.g = N'(1) << w;
    exq.push_back(e);
  endfunction

  task automatic add_pkt(input int i, input logic [7:0] p[$], input bit closed);
    for (int k = 0; k < p.size(); k++) begin
      ent_t e;
      e.d = p[k];
      e.l = closed && k == p.size() - 1;
      rq[i].push_back(e);
      mq[i].push_back(e);
    end
  endtask

  // Packet-level model: serve pending packets round-robin, frame and escape each one.
  task automatic predict();
    int w;
    bit done;
    ent_t e;
    forever begin
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && mq[(mptr + k) % N].size() > 0) w = (mptr + k) % N;
      if (w < 0) break;
      push(8'h01, w);
      done = 1'b0;
      while (!done && mq[w].size() > 0) begin
        e = mq[w].pop_front();
        if (e.d inside {8'h01, 8'h17, 8'h18}) push(8'h18, w);
        push(e.d, w);
        done = e.l;
      end
      push(8'h17, w);
      mptr = w;
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while ((exq.size() > 0 || pending()) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk(n < 6000, {name, "_drain"}, exq.size(), 0);
    repeat (3) @(negedge clk);
    chk(grant == '0, {name, "_grant_idle"}, grant, 0);
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      rq[i].delete();
      mq[i].delete();
    end
    exq.delete();
    mptr = N - 1;
    drive();
    #1;
    chk(!tx_send && grant == '0 && req_ack == '0 && !abort && tx_data == 8'h00,
        "reset_outputs", {tx_send, grant, req_ack}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Requester drivers and a 10-cycle-per-byte transmitter model, updated just after each edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++) if (acked[i] && rq[i].size() > 0) rq[i].delete(0);
    bcnt = sent ? 10 : bcnt > 0 ? bcnt - 1 : 0;
    tx_busy = busy_force || bcnt != 0;
    drive();
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    acked = req_ack;
    sent = tx_send;
    if (abort === 1'b1) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    if (tx_send === 1'b1) begin
      sends++;
      chk(!tx_busy, "send_while_busy", tx_busy, 0);
      chk(!prev_send, "send_no_gap", prev_send, 0);
      if (exq.size() == 0) chk(1'b0, "unexpected_send", tx_data, 0);
      else begin
        e = exq.pop_front();
        chk(tx_data == e.b, "tx_data", tx_data, e.b);
        chk(grant == e.g, "grant_owner", grant, e.g);
      end
    end
    for (int i = 0; i < N; i++)
      if (req_ack[i] === 1'b1) begin
        ack_cnt[i]++;
        ack_cyc[i] = cyc;
        chk(rq[i].size() > 0 && tx_data == rq[i][0].d, "ack_data", tx_data,
            rq[i].size() > 0 ? int'(rq[i][0].d) : 0);
      end
    if (req_ack !== '0) chk(tx_send && req_ack == grant, "ack_owner", req_ack, grant);
    prev_send = tx_send;
  end

  initial begin
    logic [7:0] p[$];
    logic [7:0] sp[3];
    int s0, mask, np, len, n;
    int nb[N];
    sp = '{8'h01, 8'h17, 8'h18};
    repeat (2) @(negedge clk);
    chk(!tx_send && grant == '0 && req_ack == '0 && !abort && tx_data == 8'h00,
        "init_reset", {tx_send, grant, req_ack}, 0);
    reset = 1'b0;
    // plain packet, also checks start latency
    clr();
    @(posedge clk);
    #2;
    p = {8'h41, 8'h42};
    add_pkt(0, p, 1'b1);
    predict();
    drive();
    @(negedge clk);
    chk(!tx_send, "lat_idle", tx_send, 0);
    @(negedge clk);
    chk(tx_send && tx_data == 8'h01, "lat_start", {tx_send, tx_data}, 9'h101);
    drain("plain");
    chk(ack_cnt[0] == 2, "plain_acks", ack_cnt[0], 2);
    // all-escaped packet
    clr();
    @(posedge clk);
    #2;
    p = {8'h18, 8'h01, 8'h17};
    add_pkt(1, p, 1'b1);
    predict();
    drive();
    drain("escape");
    chk(ack_cnt[1] == 3, "escape_acks", ack_cnt[1], 3);
    // simultaneous requesters from reset alternate
    do_reset();
    clr();
    @(posedge clk);
    #2;
    p = {8'hAA};
    add_pkt(0, p, 1'b1);
    add_pkt(0, p, 1'b1);
    p = {8'hBB};
    add_pkt(2, p, 1'b1);
    add_pkt(2, p, 1'b1);
    predict();
    drive();
    drain("rr");
    chk(ack_cnt[0] == 2 && ack_cnt[2] == 2, "rr_acks", ack_cnt[0] * 16 + ack_cnt[2], 8'h22);
    // mid-packet stall forces abort
    clr();
    @(posedge clk);
    #2;
    p = {8'h10};
    add_pkt(3, p, 1'b0);
    predict();
    drive();
    drain("timeout");
    chk(abort_cnt == 1, "abort_once", abort_cnt, 1);
    chk(abort_cyc - ack_cyc[3] == T_OUT + 1, "abort_time", abort_cyc - ack_cyc[3], T_OUT + 1);
    // reset mid-packet while the transmitter is busy
    clr();
    @(posedge clk);
    #2;
    p = {8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    add_pkt(0, p, 1'b1);
    predict();
    drive();
    s0 = sends;
    n = 0;
    while (sends < s0 + 3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(n < 300, "mid_reset_wait", sends - s0, 3);
    repeat (2) @(negedge clk);
    chk(grant == 4'b0001, "pre_reset_grant", grant, 1);
    do_reset();
    clr();
    @(posedge clk);
    #2;
    p = {8'h55};
    add_pkt(0, p, 1'b1);
    predict();
    drive();
    drain("post_reset");
    // transmitter held busy
    clr();
    @(posedge clk);
    #2;
    busy_force = 1'b1;
    tx_busy = 1'b1;
    p = {8'h33};
    add_pkt(2, p, 1'b1);
    predict();
    drive();
    s0 = sends;
    repeat (100) @(negedge clk);
    chk(sends == s0, "busy_hold_no_send", sends - s0, 0);
    busy_force = 1'b0;
    drain("busy");
    // random batches
    for (int r = 0; r < 8; r++) begin
      clr();
      @(posedge clk);
      #2;
      mask = $urandom_range(1, 15);
      for (int i = 0; i < N; i++) begin
        nb[i] = 0;
        np = mask[i] ? $urandom_range(1, 2) : 0;
        for (int k = 0; k < np; k++) begin
          len = $urandom_range(1, 4);
          p.delete();
          for (int b = 0; b < len; b++)
            p.push_back($urandom_range(0, 3) == 0 ? sp[$urandom_range(0, 2)] : 8'($urandom));
          add_pkt(i, p, 1'b1);
          nb[i] += len;
        end
      end
      predict();
      drive();
      drain("rand");
      for (int i = 0; i < N; i++) chk(ack_cnt[i] == nb[i], "rand_acks", ack_cnt[i], nb[i]);
    end
    chk(abort_cnt == 1, "abort_total", abort_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
